// File: rtl/sb_slave_mem_if.sv
// Bus signal bundle between a system-bus master/decoder and the sb_slave_mem
// storage slave; clock and reset travel as plain ports beside it.
interface sb_slave_mem_if;
    logic        sb_sel_s;
    logic [1:0]  sb_trans_s;
    logic [31:0] sb_addr_s;
    logic        sb_write_s;
    logic [2:0]  sb_size_s;
    logic [2:0]  sb_burst_s;
    logic [31:0] sb_wdata_s;
    logic        sb_ready_s;
    logic [1:0]  sb_resp_s;
    logic [31:0] sb_rdata_s;

    modport master (
        output sb_sel_s, sb_trans_s, sb_addr_s, sb_write_s, sb_size_s,
               sb_burst_s, sb_wdata_s,
        input  sb_ready_s, sb_resp_s, sb_rdata_s
    );

    modport slave (
        input  sb_sel_s, sb_trans_s, sb_addr_s, sb_write_s, sb_size_s,
               sb_burst_s, sb_wdata_s,
        output sb_ready_s, sb_resp_s, sb_rdata_s
    );
endinterface

// File: rtl/sb_slave_mem.sv
// Pipelined system-bus storage slave: byte-lane writes, programmable wait
// states, two-cycle error response and write-to-read forwarding.
module sb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic           sb_clk,
    input logic           sb_resetn,
    sb_slave_mem_if.slave sb
);
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  WS_L      = 2'(WAIT_STATES);

    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_OKAY  = 2'd1;
    localparam logic [1:0] RESP_ERROR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            3'd0:    m = 4'b0001 << lo;
            3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       be_q, be_d;
    logic             write_q, write_d;
    logic             ready_q, ready_d;
    logic [1:0]       resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      mem_q [MEM_WORDS];

    logic [31:0]      offset_s;
    logic             in_range_s;
    logic             misalign_s;
    logic             err_s;
    logic             accept_s;
    logic             commit_s;
    logic             fwd_s;
    logic [IDX_W-1:0] in_idx_s;
    logic [31:0]      rd_word_s;
    logic             unused_s;

    assign offset_s   = sb.sb_addr_s - BASE_ADDR;
    assign in_range_s = (sb.sb_addr_s >= BASE_ADDR) && (offset_s < WIN_BYTES);
    assign in_idx_s   = offset_s[IDX_W+1:2];
    assign err_s      = !in_range_s || misalign_s;
    assign accept_s   = sb.sb_sel_s && ready_q && sb.sb_trans_s[1];
    assign unused_s   = ^{sb.sb_burst_s, sb.sb_trans_s[0]};

    // Size legality and natural alignment of the incoming address phase
    always_comb begin
        case (sb.sb_size_s)
            3'd0:    misalign_s = 1'b0;
            3'd1:    misalign_s = sb.sb_addr_s[0];
            3'd2:    misalign_s = (sb.sb_addr_s[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    // Next-state and transfer capture; ready-high states may launch a new transfer
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        be_d    = be_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_d = ST_ERR1;
                    end else begin
                        idx_d   = in_idx_s;
                        be_d    = lane_mask(sb.sb_size_s, sb.sb_addr_s[1:0]);
                        write_d = sb.sb_write_s;
                        if (WS_L != 2'd0) begin
                            state_d = ST_WAIT;
                            wcnt_d  = WS_L;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 2'd1;
                if (wcnt_q <= 2'd1) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 2'd0;
            end
        endcase
    end

    // A read entering DATA straight behind a committing write to the same word sees the new lanes
    assign commit_s  = (state_q == ST_DATA) && write_q;
    assign fwd_s     = commit_s && (idx_q == idx_d);
    assign rd_word_s = mem_q[idx_d];

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        ready_d = 1'b1;
        resp_d  = RESP_NONE;
        rdata_d = rdata_q;
        case (state_d)
            ST_WAIT: ready_d = 1'b0;
            ST_DATA: resp_d  = RESP_OKAY;
            ST_ERR1: begin
                ready_d = 1'b0;
                resp_d  = RESP_ERROR;
            end
            ST_ERR2: resp_d = RESP_ERROR;
            default: begin
                ready_d = 1'b1;
                resp_d  = RESP_NONE;
            end
        endcase
        if ((state_d == ST_DATA) && !write_d) begin
            rdata_d = fwd_s ? merge_lanes(rd_word_s, sb.sb_wdata_s, be_q) : rd_word_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and output registers
    always_ff @(posedge sb_clk or negedge sb_resetn) begin
        if (!sb_resetn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 2'd0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            resp_q  <= RESP_NONE;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            write_q <= write_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array keeps its contents through reset
    always_ff @(posedge sb_clk) begin
        if (commit_s) begin
            mem_q[idx_q] <= merge_lanes(mem_q[idx_q], sb.sb_wdata_s, be_q);
        end
    end

    assign sb.sb_ready_s = ready_q;
    assign sb.sb_resp_s  = resp_q;
    assign sb.sb_rdata_s = rdata_q;

endmodule

// File: doc/sb_slave_mem.md
SB_SLAVE_MEM -- requirements
Module: sb_slave_mem

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BASE_ADDR, 32'h0000_0000, 64-byte aligned base of the slave window.
- MEM_WORDS, 16, number of 32-bit storage words (window = MEM_WORDS*4 bytes).
- WAIT_STATES, 0, extra ready-low cycles per OKAY data phase (0..3).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- sb_clk  in  1  sole clock, rising edge.
- sb_resetn  in  1  reset.
- sb_sel_s  in  1  slave selected by decoder.
- sb_trans_s  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- sb_addr_s  in  32  byte address.
- sb_write_s  in  1  1=write, 0=read.
- sb_size_s  in  3  0=byte, 1=halfword, 2=word.
- sb_burst_s  in  3  burst type, INCR=1 (informational only).
- sb_wdata_s  in  32  write data, valid in data phase.
- sb_ready_s  out  1  data phase complete / slave ready.
- sb_resp_s  out  2  NONE=0, OKAY=1, ERROR=2 (SPLIT=3 never driven).
- sb_rdata_s  out  32  read data, valid when ready=1 and resp=OKAY on a read.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, on ports sb_clk and sb_resetn.

Function
REQ-004 An address phase SHALL be accepted on a rising edge where sb_sel_s=1, sb_ready_s=1 and sb_trans_s is NONSEQ or SEQ; addr, write and size SHALL be registered.
REQ-005 A transfer SHALL be in error if addr is outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4), size>2, or addr is misaligned to size.
REQ-006 State machine SHALL have states IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: ready=1, resp=NONE; accepted OK transfer -> WAIT if WAIT_STATES>0, else DATA; accepted error transfer -> ERR1.
- WAIT: ready=0, resp=NONE; a counter loads WAIT_STATES at entry, decrements each cycle, and goes to DATA after WAIT_STATES cycles.
- DATA: ready=1, resp=OKAY; a write commits here; a read drives rdata; a new accepted transfer in the same cycle pipelines to WAIT/DATA/ERR1; otherwise -> IDLE.
- ERR1: ready=0, resp=ERROR -> ERR2.
- ERR2: ready=1, resp=ERROR; no memory access; may accept a new address phase like DATA.
REQ-007 BUSY or IDLE trans, or sb_sel_s=0, SHALL not start a transfer; the state returns to IDLE after any pending data phase completes.
REQ-008 Writes SHALL update only the addressed byte lanes: byte lane addr[1:0]; halfword lanes 2*addr[1] and +1; word all four lanes. Data SHALL be taken from the matching sb_wdata_s lanes in the DATA cycle.
REQ-009 Reads SHALL return the full 32-bit word at index (addr-BASE_ADDR)>>2 on all lanes, with zero added latency beyond WAIT_STATES.
REQ-010 A read whose address phase overlaps the preceding write's DATA cycle to the same word SHALL return the newly written lanes (forwarding).
REQ-011 sb_rdata_s SHALL hold its last value outside read DATA cycles.
REQ-012 Address and data phase inputs SHALL be ignored while ready=0, except sb_wdata_s in the DATA cycle.

Reset
REQ-013 While sb_resetn=0: state=IDLE, wait counter=0, sb_ready_s=1, sb_resp_s=0, sb_rdata_s=0.
REQ-014 Memory contents SHALL NOT be reset.
REQ-015 Reset asserted mid-transfer SHALL abort it with no memory write; the first cycle after release SHALL be IDLE.

Verification
REQ-016 WAIT_STATES=0: word write 0xDEADBEEF to BASE+0x8, then read BASE+0x8 -> ready=1 with no stall, resp=OKAY, rdata=0xDEADBEEF.
REQ-017 Byte write 0xAA to BASE+0x9 over word 0x11223344 -> read returns 0x1122AA44.
REQ-018 Back-to-back INCR burst of 4 words (NONSEQ,SEQ,SEQ,SEQ) from BASE+0x0 with WAIT_STATES=2 -> each data phase shows 2 ready-low cycles, then OKAY; a readback matches.
REQ-019 Access to BASE+0x40, or word at BASE+0x2 -> ERR1 (ready=0, resp=2) then ERR2 (ready=1, resp=2); memory unchanged.
REQ-020 Write to BASE+0x4 immediately followed by a read to BASE+0x4 -> read returns the new data (forwarding).
REQ-021 Assert sb_resetn low during WAIT of a write -> ready=1, resp=0 immediately; the target word keeps its old value.
